// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 bus arbiter: command encodings, FSM states, owner ids.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package l2_arb_pkg;

    localparam int DEF_ADDR_W = 26;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RFO   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // On a tie the requester that did not win last time goes first.
    function automatic owner_t rr_pick(input logic req_ic, input logic req_dc, input owner_t last);
        if (req_ic && req_dc) return (last == OWN_DC) ? OWN_IC : OWN_DC;
        if (req_dc)           return OWN_DC;
        return OWN_IC;
    endfunction

endpackage

// File: rtl/l2_arb_rr.sv
// Two-input round-robin picker; remembers the last accepted winner.
// Latency: winner is combinational; history updates on the accept edge.
// Backpressure: none, history only moves when accept is strobed.
module l2_arb_rr
    import l2_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_ic,
    input  logic   req_dc,
    input  logic   accept,
    output owner_t winner
);

    owner_t last_gnt;

    assign winner = rr_pick(req_ic, req_dc, last_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= OWN_DC;
        end else if (accept) begin
            last_gnt <= winner;
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares the L2 request bus between icache and dcache, one transaction at a time.
// Latency: ack/l2_valid one cycle after req, done one cycle after l2_done or timeout; all outputs registered.
// Backpressure: l2_ready stalls hold ISSUE indefinitely; ARB_STATS_EN adds saturating grant counters.
module l2_bus_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic [1:0]        dc_cmd,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_ack,
    output logic              dc_done,
    output logic              l2_valid,
    output logic [1:0]        l2_cmd,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_ready,
    input  logic              l2_done,
    output logic              err,
    output logic [31:0]       ic_grants,
    output logic [31:0]       dc_grants
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            winner;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic              ic_ack_d, dc_ack_d, ic_done_d, dc_done_d, err_d;
    logic              ic_vld, dc_vld, accept;

    // A dcache request carrying CMD_NONE is not a request at all.
    assign ic_vld = ic_req;
    assign dc_vld = dc_req && (dc_cmd != CMD_NONE);

    l2_arb_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_ic (ic_vld),
        .req_dc (dc_vld),
        .accept (accept),
        .winner (winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        cmd_d     = l2_cmd;
        addr_d    = l2_addr;
        ic_ack_d  = 1'b0;
        dc_ack_d  = 1'b0;
        ic_done_d = 1'b0;
        dc_done_d = 1'b0;
        err_d     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_vld || dc_vld) begin
                    accept   = 1'b1;
                    owner_d  = winner;
                    cmd_d    = (winner == OWN_IC) ? CMD_READ : dc_cmd;
                    addr_d   = (winner == OWN_IC) ? ic_addr : dc_addr;
                    ic_ack_d = (winner == OWN_IC);
                    dc_ack_d = (winner == OWN_DC);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    cmd_d   = CMD_NONE;
                    addr_d  = '0;
                end
            end
            WAIT: begin
                // Completion beats a timeout landing on the same cycle.
                if (l2_done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ic_done_d = (owner_q == OWN_IC);
                    dc_done_d = (owner_q == OWN_DC);
                    err_d     = !l2_done;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IC;
            cnt_q    <= '0;
            ic_ack   <= 1'b0;
            dc_ack   <= 1'b0;
            ic_done  <= 1'b0;
            dc_done  <= 1'b0;
            err      <= 1'b0;
            l2_valid <= 1'b0;
            l2_cmd   <= CMD_NONE;
            l2_addr  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            ic_ack   <= ic_ack_d;
            dc_ack   <= dc_ack_d;
            ic_done  <= ic_done_d;
            dc_done  <= dc_done_d;
            err      <= err_d;
            l2_valid <= (state_d == ISSUE);
            l2_cmd   <= cmd_d;
            l2_addr  <= addr_d;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_grants <= '0;
            dc_grants <= '0;
        end else begin
            if (ic_ack && ic_grants != 32'hFFFF_FFFF) ic_grants <= ic_grants + 32'd1;
            if (dc_ack && dc_grants != 32'hFFFF_FFFF) dc_grants <= dc_grants + 32'd1;
        end
    end
`else
    assign ic_grants = 32'b0;
    assign dc_grants = 32'b0;
`endif

endmodule
